fbuff_port_arbiter: RTL

//  Shares the single-port frame buffer RAM between the line buffer fill engine (read-only, never stalled)
//  and a host/pattern write port. Host writes are queued in a small FIFO and drained only in cycles
//  the display path leaves the RAM idle. Sits between line_buffers and frame_buffer in the VGA top.

---
 rtl/fbuff_port_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/fbuff_port_arbiter.sv
// Frame buffer port arbiter: the display read path always wins; host writes are queued and drained in idle cycles.
// Optional full-frame clear engine is enabled by defining FBUFF_CLEAR_EN.
module fbuff_port_arbiter #(
  parameter int FBUFF_ADDR_WIDTH = 12,
  parameter int FBUFF_DATA_WIDTH = 60,
  parameter int FBUFF_DEPTH      = 3840,
  parameter int WR_FIFO_DEPTH    = 4,
  parameter int STARVE_LIMIT     = 1024,
  parameter logic [FBUFF_DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                                 clk_i,
  input  logic                                 rstn_i,
  input  logic                                 disp_en_i,
  input  logic [FBUFF_ADDR_WIDTH-1:0]          disp_addr_i,
  output logic [FBUFF_DATA_WIDTH-1:0]          disp_data_o,
  output logic                                 disp_valid_o,
  input  logic                                 wr_valid_i,
  output logic                                 wr_ready_o,
  input  logic [FBUFF_ADDR_WIDTH-1:0]          wr_addr_i,
  input  logic [FBUFF_DATA_WIDTH-1:0]          wr_data_i,
  output logic [$clog2(WR_FIFO_DEPTH):0]       fifo_level_o,
  output logic                                 starve_o,
  input  logic                                 clear_req_i,
  output logic                                 clear_busy_o,
  output logic                                 fbuff_en_o,
  output logic                                 fbuff_wen_o,
  output logic [FBUFF_ADDR_WIDTH-1:0]          fbuff_addr_o,
  output logic [FBUFF_DATA_WIDTH-1:0]          fbuff_data_o,
  input  logic [FBUFF_DATA_WIDTH-1:0]          fbuff_data_i
);

  localparam int AW = FBUFF_ADDR_WIDTH;
  localparam int DW = FBUFF_DATA_WIDTH;
  localparam int PW = $clog2(WR_FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DISP  = 2'd1,
    ST_WRITE = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

  logic [AW-1:0] fifo_addr_r [WR_FIFO_DEPTH];
  logic [DW-1:0] fifo_data_r [WR_FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [LW-1:0] level_r;
  logic [SW-1:0] starve_cnt_r;
  state_t        state_r;
  state_t        grant_s;
  logic          busy_s;
  logic [AW-1:0] clr_addr_s;
  logic          empty_s;
  logic          full_s;
  logic          push_s;
  logic          pop_s;

  assign empty_s = (level_r == {LW{1'b0}});
  assign full_s  = (level_r == LW'(WR_FIFO_DEPTH));
  assign push_s  = wr_valid_i && wr_ready_o;
  assign pop_s   = (grant_s == ST_WRITE);

`ifdef FBUFF_CLEAR_EN
  logic          clear_busy_r;
  logic [AW-1:0] clear_row_r;

  // Clear engine: walks rows upward, advancing only on cycles it owns the RAM.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      clear_busy_r <= 1'b0;
      clear_row_r  <= {AW{1'b0}};
    end else if (!clear_busy_r) begin
      if (clear_req_i) begin
        clear_busy_r <= 1'b1;
        clear_row_r  <= {AW{1'b0}};
      end
    end else if (grant_s == ST_CLEAR) begin
      if (clear_row_r == AW'(FBUFF_DEPTH - 1)) begin
        clear_busy_r <= 1'b0;
      end
      clear_row_r <= clear_row_r + {{(AW-1){1'b0}}, 1'b1};
    end
  end

  assign busy_s     = clear_busy_r;
  assign clr_addr_s = clear_row_r;
`else
  logic unused_clear_s;

  assign busy_s         = 1'b0;
  assign clr_addr_s     = {AW{1'b0}};
  assign unused_clear_s = clear_req_i & (FBUFF_DEPTH > 0);
`endif

  // Per-cycle grant: display > clear > FIFO; RAM controls are combinational for zero added read latency.
  always_comb begin
    grant_s      = ST_IDLE;
    fbuff_en_o   = 1'b0;
    fbuff_wen_o  = 1'b0;
    fbuff_addr_o = {AW{1'b0}};
    fbuff_data_o = {DW{1'b0}};
    if (disp_en_i) begin
      grant_s      = ST_DISP;
      fbuff_en_o   = 1'b1;
      fbuff_addr_o = disp_addr_i;
    end else if (busy_s) begin
      grant_s      = ST_CLEAR;
      fbuff_en_o   = 1'b1;
      fbuff_wen_o  = 1'b1;
      fbuff_addr_o = clr_addr_s;
      fbuff_data_o = CLEAR_VALUE;
    end else if (!empty_s) begin
      grant_s      = ST_WRITE;
      fbuff_en_o   = 1'b1;
      fbuff_wen_o  = 1'b1;
      fbuff_addr_o = fifo_addr_r[rd_ptr_r];
      fbuff_data_o = fifo_data_r[rd_ptr_r];
    end else begin
      grant_s      = ST_IDLE;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      fifo_addr_r[wr_ptr_r] <= wr_addr_i;
      fifo_data_r[wr_ptr_r] <= wr_data_i;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally because depth is a power of two.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      if (pop_s)  rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + {{(LW-1){1'b0}}, 1'b1};
        2'b01:   level_r <= level_r - {{(LW-1){1'b0}}, 1'b1};
        default: level_r <= level_r;
      endcase
    end
  end

  // Starvation counter and previous-cycle grant register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      starve_cnt_r <= {SW{1'b0}};
      state_r      <= ST_IDLE;
    end else begin
      state_r <= grant_s;
      if (empty_s || pop_s) begin
        starve_cnt_r <= {SW{1'b0}};
      end else if (starve_cnt_r != SW'(STARVE_LIMIT)) begin
        starve_cnt_r <= starve_cnt_r + {{(SW-1){1'b0}}, 1'b1};
      end
    end
  end

  assign wr_ready_o   = !full_s && !busy_s;
  assign fifo_level_o = level_r;
  assign starve_o     = (starve_cnt_r == SW'(STARVE_LIMIT));
  assign disp_valid_o = (state_r == ST_DISP);
  assign clear_busy_o = busy_s;
  assign disp_data_o  = fbuff_data_i;

endmodule
